// File: rtl/letc_core_mem_arb_pkg.sv
// Shared types for the core memory-port arbiter: address/size types,
// FSM state, transaction owner and the captured request record.
package letc_core_mem_arb_pkg;

    typedef logic [31:0] paddr_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } mem_arb_state_e;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } mem_owner_e;

    typedef struct packed {
        paddr_t      addr;
        logic        write;
        size_e       size;
        logic [31:0] wdata;
    } mem_req_s;

    // Instruction fetches are always word reads.
    function automatic mem_req_s fetch_req(input paddr_t addr);
        mem_req_s r;
        r.addr  = addr;
        r.write = 1'b0;
        r.size  = SIZE_WORD;
        r.wdata = 32'h0;
        return r;
    endfunction

endpackage

// File: rtl/letc_core_mem_arb_if.sv
// Downstream single-port memory bus: one request channel with valid/ready
// and one response channel (valid only).
interface letc_core_mem_arb_if;
    import letc_core_mem_arb_pkg::*;

    logic        req_valid;
    logic        req_ready;
    paddr_t      req_addr;
    logic        req_write;
    size_e       req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_addr, req_write, req_size, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_size, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/letc_core_mem_arb_aging.sv
// Two-input priority arbiter: req[1] (data) beats req[0] (fetch) unless
// fetch has lost STARVE_LIMIT consecutive arbitrations. STARVE_LIMIT=0
// gives strict data priority.
module letc_core_mem_arb_aging #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o
);

    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             starved;
    logic             fetch_wins;

    assign starved    = (STARVE_LIMIT != 0) && (cnt_q == LIMIT);
    assign fetch_wins = req_i[0] && (!req_i[1] || starved);
    assign grant_o    = enable_i ? {req_i[1] & ~fetch_wins, fetch_wins} : 2'b00;

    // Count observed fetch losses (saturating); a fetch grant restarts aging.
    always_comb begin
        cnt_d = cnt_q;
        if (enable_i) begin
            if (grant_o[0]) begin
                cnt_d = '0;
            end else if (req_i[0] && (cnt_q != LIMIT)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Starve counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/letc_core_mem_arb.sv
// Shares one memory port between instruction fetch and data access.
// One transaction outstanding; responses routed to the owning requester;
// a fetch flush drops the fetch response while the bus still completes.
module letc_core_mem_arb
    import letc_core_mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_valid_i,
    output logic        if_req_ready_o,
    input  paddr_t      if_req_addr_i,
    input  logic        if_flush_i,
    output logic        if_rsp_valid_o,
    output logic [31:0] if_rsp_rdata_o,
    input  logic        d_req_valid_i,
    output logic        d_req_ready_o,
    input  paddr_t      d_req_addr_i,
    input  logic        d_req_write_i,
    input  size_e       d_req_size_i,
    input  logic [31:0] d_req_wdata_i,
    output logic        d_rsp_valid_o,
    output logic [31:0] d_rsp_rdata_o,
    letc_core_mem_arb_if.master mem
);

    mem_arb_state_e state_q;
    mem_owner_e     owner_q;
    logic           drop_q;
    logic           req_vld_q;
    mem_req_s       req_q;

    logic [1:0]     arb_req;
    logic [1:0]     arb_gnt;
    logic           rsp_hit;
    logic           fetch_rsp;
    logic           data_rsp;

    // A flushed fetch does not compete and is not counted as a loss.
    assign arb_req = {d_req_valid_i, if_req_valid_i & ~if_flush_i};

    letc_core_mem_arb_aging #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_aging (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (state_q == IDLE),
        .req_i    (arb_req),
        .grant_o  (arb_gnt)
    );

    assign if_req_ready_o = arb_gnt[0];
    assign d_req_ready_o  = arb_gnt[1];

    // Responses only count while waiting; a same-cycle flush still kills a fetch response.
    assign rsp_hit   = (state_q == RSP) && mem.rsp_valid;
    assign fetch_rsp = rsp_hit && (owner_q == OWNER_FETCH) && !drop_q && !if_flush_i;
    assign data_rsp  = rsp_hit && (owner_q == OWNER_DATA);

    assign if_rsp_valid_o = fetch_rsp;
    assign if_rsp_rdata_o = fetch_rsp ? mem.rsp_rdata : 32'h0;
    assign d_rsp_valid_o  = data_rsp;
    assign d_rsp_rdata_o  = data_rsp ? mem.rsp_rdata : 32'h0;

    assign mem.req_valid = req_vld_q;
    assign mem.req_addr  = req_q.addr;
    assign mem.req_write = req_q.write;
    assign mem.req_size  = req_q.size;
    assign mem.req_wdata = req_q.wdata;

    // Transaction FSM: capture the granted request, hold it until accepted, await the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWNER_FETCH;
            drop_q    <= 1'b0;
            req_vld_q <= 1'b0;
            req_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_gnt[1]) begin
                        req_q     <= '{addr: d_req_addr_i, write: d_req_write_i,
                                       size: d_req_size_i, wdata: d_req_wdata_i};
                        owner_q   <= OWNER_DATA;
                        drop_q    <= 1'b0;
                        req_vld_q <= 1'b1;
                        state_q   <= REQ;
                    end else if (arb_gnt[0]) begin
                        req_q     <= fetch_req(if_req_addr_i);
                        owner_q   <= OWNER_FETCH;
                        drop_q    <= 1'b0;
                        req_vld_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (if_flush_i && (owner_q == OWNER_FETCH)) begin
                        drop_q <= 1'b1;
                    end
                    if (mem.req_ready) begin
                        req_vld_q <= 1'b0;
                        state_q   <= RSP;
                    end
                end
                RSP: begin
                    if (mem.rsp_valid) begin
                        drop_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (if_flush_i && (owner_q == OWNER_FETCH)) begin
                        drop_q <= 1'b1;
                    end
                end
                default: begin
                    req_vld_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_letc_core_mem_arb.sv
// Directed bench for letc_core_mem_arb: expected memory requests and
// responses are queued by the stimulus; a negedge monitor pops and compares.
module tb_letc_core_mem_arb;
    import letc_core_mem_arb_pkg::*;

    typedef struct {
        mem_owner_e  owner;
        bit          chk;
        logic [31:0] rdata;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_flush, if_rsp_valid;
    paddr_t      if_req_addr;
    logic [31:0] if_rsp_rdata;
    logic        d_req_valid, d_req_ready, d_req_write, d_rsp_valid;
    paddr_t      d_req_addr;
    size_e       d_req_size;
    logic [31:0] d_req_wdata, d_rsp_rdata;

    int checks = 0;
    int errors = 0;
    int cfg_stall = 0;
    int cfg_wait = 0;
    int inject_cnt = 0;

    mem_req_s    exp_mem[$];
    rsp_t        exp_rsp[$];
    logic [31:0] mem_data[$];
    mem_req_s    mon_m;
    rsp_t        mon_r;

    letc_core_mem_arb_if mem_if ();

    letc_core_mem_arb #(.STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_req_valid_i (if_req_valid),
        .if_req_ready_o (if_req_ready),
        .if_req_addr_i  (if_req_addr),
        .if_flush_i     (if_flush),
        .if_rsp_valid_o (if_rsp_valid),
        .if_rsp_rdata_o (if_rsp_rdata),
        .d_req_valid_i  (d_req_valid),
        .d_req_ready_o  (d_req_ready),
        .d_req_addr_i   (d_req_addr),
        .d_req_write_i  (d_req_write),
        .d_req_size_i   (d_req_size),
        .d_req_wdata_i  (d_req_wdata),
        .d_rsp_valid_o  (d_rsp_valid),
        .d_rsp_rdata_o  (d_rsp_rdata),
        .mem            (mem_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: stalls ready cfg_stall cycles, answers cfg_wait cycles after accept.
    initial begin
        bit acc;
        bit in_rsp = 1'b0;
        bit req_seen = 1'b0;
        int stall_left = 0;
        int wait_left = 0;
        int inject_seen = 0;
        mem_if.req_ready = 1'b0;
        mem_if.rsp_valid = 1'b0;
        mem_if.rsp_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            acc = mem_if.req_ready;
            mem_if.req_ready = 1'b0;
            mem_if.rsp_valid = 1'b0;
            mem_if.rsp_rdata = 32'h0;
            if (!rst_n) begin
                in_rsp   = 1'b0;
                req_seen = 1'b0;
            end else begin
                if (acc) begin
                    in_rsp    = 1'b1;
                    wait_left = cfg_wait;
                    req_seen  = 1'b0;
                end
                if (inject_cnt != inject_seen) begin
                    inject_seen      = inject_cnt;
                    mem_if.rsp_valid = 1'b1;
                    mem_if.rsp_rdata = 32'hBAD0BAD0;
                end else if (in_rsp) begin
                    if (wait_left == 0) begin
                        mem_if.rsp_valid = 1'b1;
                        mem_if.rsp_rdata = (mem_data.size() != 0) ? mem_data.pop_front() : 32'h0;
                        in_rsp = 1'b0;
                    end else begin
                        wait_left--;
                    end
                end
                if (mem_if.req_valid) begin
                    if (!req_seen) begin
                        req_seen   = 1'b1;
                        stall_left = cfg_stall;
                    end
                    if (stall_left > 0) stall_left--;
                    else mem_if.req_ready = 1'b1;
                end
            end
        end
    end

    // Scoreboard monitor: request fields every valid cycle, responses on each pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if_req_ready || d_req_ready)
                check("ready_onehot", {31'b0, if_req_ready & d_req_ready}, 32'h0);
            if (mem_if.req_valid) begin
                if (exp_mem.size() == 0) begin
                    check("mem_req_unexpected", {31'b0, mem_if.req_valid}, 32'h0);
                end else begin
                    mon_m = exp_mem[0];
                    check("mem_addr", mem_if.req_addr, mon_m.addr);
                    check("mem_write", {31'b0, mem_if.req_write}, {31'b0, mon_m.write});
                    check("mem_size", 32'(mem_if.req_size), 32'(mon_m.size));
                    check("mem_wdata", mem_if.req_wdata, mon_m.wdata);
                    if (mem_if.req_ready) void'(exp_mem.pop_front());
                end
            end
            if (if_rsp_valid || d_rsp_valid) begin
                if (if_rsp_valid && d_rsp_valid)
                    check("rsp_both", 32'h1, 32'h0);
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", {30'b0, if_rsp_valid, d_rsp_valid}, 32'h0);
                end else begin
                    mon_r = exp_rsp.pop_front();
                    check("rsp_owner", {31'b0, d_rsp_valid}, {31'b0, mon_r.owner == OWNER_DATA});
                    if (mon_r.chk)
                        check("rsp_rdata", if_rsp_valid ? if_rsp_rdata : d_rsp_rdata, mon_r.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1);
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_ready"}, {31'b0, if_req_ready}, 32'h0);
        check({tag, "_d_ready"}, {31'b0, d_req_ready}, 32'h0);
        check({tag, "_if_rsp"}, {31'b0, if_rsp_valid}, 32'h0);
        check({tag, "_d_rsp"}, {31'b0, d_rsp_valid}, 32'h0);
        check({tag, "_if_rdata"}, if_rsp_rdata, 32'h0);
        check({tag, "_d_rdata"}, d_rsp_rdata, 32'h0);
        check({tag, "_mem_valid"}, {31'b0, mem_if.req_valid}, 32'h0);
        check({tag, "_mem_addr"}, mem_if.req_addr, 32'h0);
        check({tag, "_mem_write"}, {31'b0, mem_if.req_write}, 32'h0);
        check({tag, "_mem_size"}, 32'(mem_if.req_size), 32'h0);
        check({tag, "_mem_wdata"}, mem_if.req_wdata, 32'h0);
    endtask

    // Wait (bounded) for the selected ready; leaves the request valid.
    task automatic wait_grant(input bit is_data, input string tag);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            #1;
            n++;
            seen = is_data ? d_req_ready : if_req_ready;
        end
        if (!seen) check({tag, "_grant_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic issue_data(input paddr_t a, input bit w, input size_e s, input logic [31:0] wd,
                              input string tag);
        d_req_addr  = a;
        d_req_write = w;
        d_req_size  = s;
        d_req_wdata = wd;
        d_req_valid = 1'b1;
        wait_grant(1'b1, tag);
        @(posedge clk);
        #1;
        d_req_valid = 1'b0;
    endtask

    // Bounded wait until every queued expectation has been consumed.
    task automatic wait_idle(input string tag);
        int n = 0;
        while ((exp_rsp.size() != 0 || exp_mem.size() != 0) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_rsp.size() != 0 || exp_mem.size() != 0)
            check({tag, "_drain_timeout"}, 32'(exp_rsp.size() + exp_mem.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        if_req_valid = 1'b0; if_req_addr = '0; if_flush = 1'b0;
        d_req_valid = 1'b0; d_req_addr = '0; d_req_write = 1'b0;
        d_req_size = SIZE_BYTE; d_req_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single fetch, immediate ready and response
        exp_mem.push_back('{addr: 32'h100, write: 1'b0, size: SIZE_WORD, wdata: 32'h0});
        exp_rsp.push_back('{owner: OWNER_FETCH, chk: 1'b1, rdata: 32'hDEADBEEF});
        mem_data.push_back(32'hDEADBEEF);
        if_req_addr  = 32'h100;
        if_req_valid = 1'b1;
        wait_grant(1'b0, "t1");
        @(negedge clk);
        #1;
        check("t1_ready_pulse", {31'b0, if_req_ready}, 32'h0);
        check("t1_mem_valid_req", {31'b0, mem_if.req_valid}, 32'h1);
        if_req_valid = 1'b0;
        wait_idle("t1");

        // 2: both valid continuously -> D D D D F D D D D F
        if_req_addr = 32'h400;
        d_req_addr = 32'h3000; d_req_write = 1'b0; d_req_size = SIZE_WORD; d_req_wdata = 32'h0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) begin
                exp_mem.push_back('{addr: 32'h400, write: 1'b0, size: SIZE_WORD, wdata: 32'h0});
                exp_rsp.push_back('{owner: OWNER_FETCH, chk: 1'b1, rdata: 32'h1000 + 32'(i)});
            end else begin
                exp_mem.push_back('{addr: 32'h3000, write: 1'b0, size: SIZE_WORD, wdata: 32'h0});
                exp_rsp.push_back('{owner: OWNER_DATA, chk: 1'b1, rdata: 32'h1000 + 32'(i)});
            end
            mem_data.push_back(32'h1000 + 32'(i));
        end
        if_req_valid = 1'b1;
        d_req_valid  = 1'b1;
        n = 0;
        while (exp_rsp.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_rsp.size() != 0) check("t2_timeout", 32'(exp_rsp.size()), 32'h0);
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        wait_idle("t2");

        // 3: byte store with ready stalled 3 cycles
        cfg_stall = 3;
        exp_mem.push_back('{addr: 32'h2000, write: 1'b1, size: SIZE_BYTE, wdata: 32'hAB});
        exp_rsp.push_back('{owner: OWNER_DATA, chk: 1'b0, rdata: 32'h0});
        mem_data.push_back(32'h55);
        issue_data(32'h2000, 1'b1, SIZE_BYTE, 32'hAB, "t3");
        wait_idle("t3");
        cfg_stall = 0;

        // 4: flush during RSP drops fetch response; pending load granted in the next IDLE
        cfg_wait = 2;
        exp_mem.push_back('{addr: 32'h500, write: 1'b0, size: SIZE_WORD, wdata: 32'h0});
        exp_mem.push_back('{addr: 32'h600, write: 1'b0, size: SIZE_WORD, wdata: 32'h0});
        exp_rsp.push_back('{owner: OWNER_DATA, chk: 1'b1, rdata: 32'h600AA});
        mem_data.push_back(32'h11111111);
        mem_data.push_back(32'h600AA);
        if_req_addr  = 32'h500;
        if_req_valid = 1'b1;
        wait_grant(1'b0, "t4");
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        d_req_addr = 32'h600; d_req_write = 1'b0; d_req_size = SIZE_WORD; d_req_wdata = 32'h0;
        d_req_valid = 1'b1;
        @(posedge clk);
        #1;
        if_flush = 1'b1;
        @(posedge clk);
        #1;
        if_flush = 1'b0;
        n = 0;
        while (!d_req_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t4_data_grant_cycle", 32'(n), 32'd3);
        @(posedge clk);
        #1;
        d_req_valid = 1'b0;
        wait_idle("t4");

        // 4b: flush in the same cycle as the fetch response
        cfg_wait = 0;
        exp_mem.push_back('{addr: 32'h700, write: 1'b0, size: SIZE_WORD, wdata: 32'h0});
        mem_data.push_back(32'h77777777);
        if_req_addr  = 32'h700;
        if_req_valid = 1'b1;
        wait_grant(1'b0, "t4b");
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        @(posedge clk);
        #1;
        if_flush = 1'b1;
        @(posedge clk);
        #1;
        if_flush = 1'b0;
        wait_idle("t4b");

        // 4c: drop does not leak into the next fetch
        exp_mem.push_back('{addr: 32'h704, write: 1'b0, size: SIZE_WORD, wdata: 32'h0});
        exp_rsp.push_back('{owner: OWNER_FETCH, chk: 1'b1, rdata: 32'h12345678});
        mem_data.push_back(32'h12345678);
        if_req_addr  = 32'h704;
        if_req_valid = 1'b1;
        wait_grant(1'b0, "t4c");
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        wait_idle("t4c");

        // 5: flush with fetch valid in IDLE blocks the grant
        if_req_addr  = 32'hA00;
        if_req_valid = 1'b1;
        if_flush     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("t5_if_ready", {31'b0, if_req_ready}, 32'h0);
            check("t5_mem_valid", {31'b0, mem_if.req_valid}, 32'h0);
        end
        exp_mem.push_back('{addr: 32'hA00, write: 1'b0, size: SIZE_WORD, wdata: 32'h0});
        exp_rsp.push_back('{owner: OWNER_FETCH, chk: 1'b1, rdata: 32'hA0A0A0A0});
        mem_data.push_back(32'hA0A0A0A0);
        @(posedge clk);
        #1;
        if_flush = 1'b0;
        wait_grant(1'b0, "t5");
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        wait_idle("t5");

        // 6: reset during RSP, late response afterwards is ignored
        cfg_wait = 20;
        exp_mem.push_back('{addr: 32'h800, write: 1'b0, size: SIZE_WORD, wdata: 32'h0});
        if_req_addr  = 32'h800;
        if_req_valid = 1'b1;
        wait_grant(1'b0, "t6");
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("t6_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cfg_wait = 0;
        @(negedge clk);
        inject_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("t6_mem_valid", {31'b0, mem_if.req_valid}, 32'h0);
            check("t6_if_rsp", {31'b0, if_rsp_valid}, 32'h0);
            check("t6_d_rsp", {31'b0, d_rsp_valid}, 32'h0);
        end
        @(posedge clk);
        #1;
        exp_mem.push_back('{addr: 32'h900, write: 1'b1, size: SIZE_HALF, wdata: 32'hBEEF});
        exp_rsp.push_back('{owner: OWNER_DATA, chk: 1'b0, rdata: 32'h0});
        mem_data.push_back(32'h0);
        issue_data(32'h900, 1'b1, SIZE_HALF, 32'hBEEF, "t6b");
        wait_idle("t6b");

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
